uart_cfg: RTL and testbench
===========================

// Module: uart_cfg
// PURPOSE
//  Runtime-configurable UART: programmable baud divisor and 5-8 data bits.
//  Optional even/odd parity and 1 or 2 stop bits; RX and TX FIFOs of parametrised depth.
//  Per-word parity/framing error flags travel through the RX FIFO; a sticky overrun flag reports dropped words.
//  Sits between the system bus (rd_uart/wr_uart strobes) and the board serial pins; 16x oversampling.
// PARAMETERS
//  FIFO_W    4    FIFO address bits; each FIFO holds 2**FIFO_W words
//  DVSR_BIT  16   width of the dvsr port and the baud counter
// PORTS
//  clk         in   1         system clock; all logic on rising edge
//  reset       in   1         asynchronous, active-low reset
//  dvsr        in   DVSR_BIT  baud divisor = f_clk/(16*baud); 0 disables tick
//  cfg_dbits   in   2         data bits: 00=5, 01=6, 10=7, 11=8
//  cfg_par_en  in   1         1 = parity bit present
//  cfg_par_odd in   1         1 = odd parity, 0 = even
//  cfg_stop2   in   1         1 = two stop bits (TX); RX checks the first only
//  rd_uart     in   1         pop RX FIFO head; ignored when rx_empty
//  wr_uart     in   1         push w_data to TX FIFO; ignored when tx_full
//  w_data      in   8         TX byte; bits above cfg_dbits are ignored
//  err_clr     in   1         clears the overrun flag
//  rx          in   1         serial input; idle high
//  tx          out  1         serial output; idle high
//  tx_full     out  1         TX FIFO full
//  tx_busy     out  1         TX FSM not idle, or TX FIFO not empty
//  rx_empty    out  1         RX FIFO empty
//  r_data      out  8         RX head data, zero-extended above cfg_dbits; valid when !rx_empty
//  r_perr      out  1         RX head word had a parity error
//  r_ferr      out  1         RX head word had a framing error (stop bit sampled low)
//  overrun     out  1         sticky: a received word was dropped because the RX FIFO was full
// BEHAVIOUR
//  Reset (async, any time, including mid-frame):
//   - tx=1, tx_busy=0, tx_full=0, rx_empty=1, overrun=0.
//   - Both FIFOs emptied; FSMs go to IDLE; baud counter cleared to 0.
//  Baud tick:
//   - Counter runs 0..dvsr-1; one-cycle tick when count==dvsr-1, then wraps to 0.
//   - If count>=dvsr-1 after dvsr changes, the counter wraps on the next cycle.
//   - dvsr==0: no ticks; both FSMs freeze in their current state.
//  Config latch: RX latches cfg_* on start detect; TX latches cfg_* on leaving IDLE.
//   Changes mid-frame take effect on the next frame.
//  RX FSM (IDLE, START, DATA, PARITY, STOP); tick count s, bit count n:
//   - IDLE: rx==0 -> START, s=0.
//   - START: at s==7, rx==1 -> IDLE (false start, nothing written); else -> DATA, s=0.
//   - DATA: sample at s==15; LSB first; after cfg_dbits+5 bits -> PARITY if par_en, else STOP.
//   - PARITY: perr = sampled bit != (XOR of data bits ^ par_odd).
//   - STOP: sample at s==15; ferr = ~rx; write {ferr,perr,data} to RX FIFO; -> IDLE.
//   - Write with FIFO full and no rd_uart in the same cycle: word dropped, overrun=1.
//   - Full FIFO with rd_uart in the same cycle: read and write both happen, no overrun.
//   - err_clr and overrun-set in the same cycle: set wins.
//  TX FSM (IDLE, START, DATA, PARITY, STOP):
//   - IDLE: TX FIFO not empty -> START on the next clk; tx=0 for 16 ticks.
//   - DATA: cfg_dbits+5 bits LSB first, 16 ticks each.
//   - PARITY (if enabled): XOR of data bits ^ par_odd.
//   - STOP: tx=1 for 16 ticks (32 if stop2); then pop TX FIFO (1-cycle done) -> IDLE.
//   - Back-to-back frames have no extra idle bit.
//  FIFOs: show-ahead (head visible without rd). Simultaneous push and pop: both occur.
//   Push when full is ignored; pop when empty is ignored.
// STRUCTURE
//  Shared package/header: cfg_dbits encodings, FSM state encodings, OVERSAMPLE=16, START_MID=7.
//  Reuse the existing fifo module: RX FIFO with B=10, TX FIFO with B=8; both W=FIFO_W.
//  One new sub-module, uart_baud_gen: runtime dvsr, wrap and disable rules above.
//  RX and TX FSMs live in uart_cfg.
// TESTING (dvsr=4 -> 64 clk per bit; tx looped to rx unless stated)
//  8N1, write 0xA5 -> tx low at the first tick after the push; frame 640 clk;
//   RX head 0xA5, perr=0, ferr=0.
//  7E2, write 0xC1 -> 7 data bits 0x41, parity 0, stop high for 128 clk; r_data=0x41, tx_busy low after frame.
//  Bench drives rx (8O1) with data 0x03 and parity bit 0 -> r_perr=1, r_data=0x03.
//  Bench drives 8N1 0x5A with stop bit low -> r_ferr=1, r_data=0x5A.
//  FIFO_W=2, 5 frames, no reads -> 4 words held, overrun=1; err_clr -> 0; 5th word absent.
//  rx low pulse of 3 ticks -> rx_empty stays 1.
//  reset pulse mid-frame -> tx=1 immediately; tx_busy=0; rx_empty=1.

Source files
------------

// File: rtl/uart_cfg_pkg.sv
// Shared definitions for the runtime-configurable UART: data-width encodings,
// FSM states, oversampling constants and small data/parity helpers.
package uart_cfg_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned START_MID  = 7;

    typedef enum logic [1:0] {
        Dbits5 = 2'b00,
        Dbits6 = 2'b01,
        Dbits7 = 2'b10,
        Dbits8 = 2'b11
    } dbits_e;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_st_e;

    // Index of the last data bit: 4..7 for 5..8 data bits.
    function automatic logic [2:0] last_bit(input logic [1:0] dbits);
        return {1'b0, dbits} + 3'd4;
    endfunction

    function automatic logic [7:0] dbits_mask(input logic [1:0] dbits);
        return 8'hff >> (2'd3 - dbits);
    endfunction

    function automatic logic par_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/fifo.sv
// Show-ahead synchronous FIFO of 2**W words of B bits; push when full is
// ignored unless a pop happens in the same cycle, pop when empty is ignored.
module fifo #(
    parameter int unsigned B = 8,
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    output logic         empty,
    output logic         full,
    output logic [B-1:0] r_data
);

    logic [B-1:0] mem_q [0:(2**W)-1];
    logic [W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic         full_q, full_d, empty_q, empty_d;
    logic         wr_en, rd_en;

    always_comb begin
        wr_en    = wr & (~full_q | rd);
        rd_en    = rd & ~empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        full_d   = full_q;
        empty_d  = empty_q;
        case ({wr_en, rd_en})
            2'b01: begin
                rd_ptr_d = rd_ptr_q + W'(1);
                full_d   = 1'b0;
                empty_d  = (rd_ptr_d == wr_ptr_q);
            end
            2'b10: begin
                wr_ptr_d = wr_ptr_q + W'(1);
                empty_d  = 1'b0;
                full_d   = (wr_ptr_d == rd_ptr_q);
            end
            2'b11: begin
                wr_ptr_d = wr_ptr_q + W'(1);
                rd_ptr_d = rd_ptr_q + W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= w_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign empty  = empty_q;
    assign full   = full_q;
    assign r_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator: one-cycle tick every dvsr clocks, none when dvsr is 0.
module uart_baud_gen #(
    parameter int unsigned DVSR_BIT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DVSR_BIT-1:0] dvsr,
    output logic                tick
);

    logic [DVSR_BIT-1:0] cnt_q, cnt_d, last;

    always_comb begin
        last  = dvsr - DVSR_BIT'(1);
        tick  = 1'b0;
        cnt_d = cnt_q + DVSR_BIT'(1);
        if (dvsr == '0) begin
            cnt_d = '0;
        end else if (cnt_q >= last) begin
            // A divisor shrunk below the current count wraps without a tick.
            cnt_d = '0;
            tick  = (cnt_q == last);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_cfg.sv
// Runtime-configurable UART with 16x oversampled RX, TX FSMs and RX/TX FIFOs;
// RX words carry per-word parity/framing flags, dropped words raise overrun.
module uart_cfg
    import uart_cfg_pkg::*;
#(
    parameter int unsigned FIFO_W   = 4,
    parameter int unsigned DVSR_BIT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DVSR_BIT-1:0] dvsr,
    input  logic [1:0]          cfg_dbits,
    input  logic                cfg_par_en,
    input  logic                cfg_par_odd,
    input  logic                cfg_stop2,
    input  logic                rd_uart,
    input  logic                wr_uart,
    input  logic [7:0]          w_data,
    input  logic                err_clr,
    input  logic                rx,
    output logic                tx,
    output logic                tx_full,
    output logic                tx_busy,
    output logic                rx_empty,
    output logic [7:0]          r_data,
    output logic                r_perr,
    output logic                r_ferr,
    output logic                overrun
);

    localparam logic [4:0] BitEnd  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] Stop2End = 5'(2 * OVERSAMPLE - 1);

    logic       tick;
    logic       rx_meta_q, rx_sync_q;

    uart_st_e   rx_st_q, rx_st_d;
    logic [4:0] rx_s_q, rx_s_d;
    logic [2:0] rx_n_q, rx_n_d;
    logic [7:0] rx_b_q, rx_b_d;
    logic       rx_perr_q, rx_perr_d;
    dbits_e     rx_dbits_q, rx_dbits_d;
    logic       rx_par_en_q, rx_par_en_d, rx_par_odd_q, rx_par_odd_d;
    logic [7:0] rx_data;
    logic [9:0] rx_wdata, rx_head;
    logic       rx_done, rx_full;
    logic       overrun_q, overrun_d;

    uart_st_e   tx_st_q, tx_st_d;
    logic [4:0] tx_s_q, tx_s_d;
    logic [2:0] tx_n_q, tx_n_d;
    logic [7:0] tx_b_q, tx_b_d, tx_head;
    logic       tx_par_q, tx_par_d;
    dbits_e     tx_dbits_q, tx_dbits_d;
    logic       tx_par_en_q, tx_par_en_d, tx_stop2_q, tx_stop2_d;
    logic       tx_q, tx_d, tx_pop, tx_empty;
    logic [4:0] tx_stop_end;

    uart_baud_gen #(.DVSR_BIT(DVSR_BIT)) u_baud (
        .clk   (clk),
        .reset (reset),
        .dvsr  (dvsr),
        .tick  (tick)
    );

    fifo #(.B(10), .W(FIFO_W)) u_rx_fifo (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd_uart),
        .wr     (rx_done),
        .w_data (rx_wdata),
        .empty  (rx_empty),
        .full   (rx_full),
        .r_data (rx_head)
    );

    fifo #(.B(8), .W(FIFO_W)) u_tx_fifo (
        .clk    (clk),
        .reset  (reset),
        .rd     (tx_pop),
        .wr     (wr_uart),
        .w_data (w_data),
        .empty  (tx_empty),
        .full   (tx_full),
        .r_data (tx_head)
    );

    always_comb begin
        rx_st_d      = rx_st_q;
        rx_s_d       = rx_s_q;
        rx_n_d       = rx_n_q;
        rx_b_d       = rx_b_q;
        rx_perr_d    = rx_perr_q;
        rx_dbits_d   = rx_dbits_q;
        rx_par_en_d  = rx_par_en_q;
        rx_par_odd_d = rx_par_odd_q;
        rx_done      = 1'b0;
        // Bits shift in at the MSB end; right-align to zero-extend short words.
        rx_data      = rx_b_q >> (3'd7 - last_bit(rx_dbits_q));
        rx_wdata     = {~rx_sync_q, rx_perr_q, rx_data};
        case (rx_st_q)
            StIdle: if (!rx_sync_q) begin
                rx_st_d      = StStart;
                rx_s_d       = '0;
                rx_n_d       = '0;
                rx_b_d       = '0;
                rx_perr_d    = 1'b0;
                rx_dbits_d   = dbits_e'(cfg_dbits);
                rx_par_en_d  = cfg_par_en;
                rx_par_odd_d = cfg_par_odd;
            end
            StStart: if (tick) begin
                if (rx_s_q == 5'(START_MID)) begin
                    rx_st_d = rx_sync_q ? StIdle : StData;
                    rx_s_d  = '0;
                end else begin
                    rx_s_d = rx_s_q + 5'd1;
                end
            end
            StData: if (tick) begin
                if (rx_s_q == BitEnd) begin
                    rx_s_d = '0;
                    rx_b_d = {rx_sync_q, rx_b_q[7:1]};
                    if (rx_n_q == last_bit(rx_dbits_q)) begin
                        rx_st_d = rx_par_en_q ? StParity : StStop;
                    end else begin
                        rx_n_d = rx_n_q + 3'd1;
                    end
                end else begin
                    rx_s_d = rx_s_q + 5'd1;
                end
            end
            StParity: if (tick) begin
                if (rx_s_q == BitEnd) begin
                    rx_perr_d = rx_sync_q != par_bit(rx_data, rx_par_odd_q);
                    rx_st_d   = StStop;
                    rx_s_d    = '0;
                end else begin
                    rx_s_d = rx_s_q + 5'd1;
                end
            end
            StStop: if (tick) begin
                if (rx_s_q == BitEnd) begin
                    rx_done = 1'b1;
                    rx_st_d = StIdle;
                end else begin
                    rx_s_d = rx_s_q + 5'd1;
                end
            end
            default: rx_st_d = StIdle;
        endcase
    end

    always_comb begin
        overrun_d = overrun_q;
        if (err_clr) overrun_d = 1'b0;
        if (rx_done && rx_full && !rd_uart) overrun_d = 1'b1;
    end

    always_comb begin
        tx_st_d     = tx_st_q;
        tx_s_d      = tx_s_q;
        tx_n_d      = tx_n_q;
        tx_b_d      = tx_b_q;
        tx_par_d    = tx_par_q;
        tx_dbits_d  = tx_dbits_q;
        tx_par_en_d = tx_par_en_q;
        tx_stop2_d  = tx_stop2_q;
        tx_pop      = 1'b0;
        tx_d        = 1'b1;
        tx_stop_end = tx_stop2_q ? Stop2End : BitEnd;
        case (tx_st_q)
            StIdle: if (!tx_empty) begin
                tx_st_d     = StStart;
                tx_s_d      = '0;
                tx_n_d      = '0;
                tx_b_d      = tx_head & dbits_mask(cfg_dbits);
                tx_par_d    = par_bit(tx_head & dbits_mask(cfg_dbits), cfg_par_odd);
                tx_dbits_d  = dbits_e'(cfg_dbits);
                tx_par_en_d = cfg_par_en;
                tx_stop2_d  = cfg_stop2;
            end
            StStart: begin
                tx_d = 1'b0;
                if (tick) begin
                    if (tx_s_q == BitEnd) begin
                        tx_st_d = StData;
                        tx_s_d  = '0;
                    end else begin
                        tx_s_d = tx_s_q + 5'd1;
                    end
                end
            end
            StData: begin
                tx_d = tx_b_q[0];
                if (tick) begin
                    if (tx_s_q == BitEnd) begin
                        tx_s_d = '0;
                        tx_b_d = tx_b_q >> 1;
                        if (tx_n_q == last_bit(tx_dbits_q)) begin
                            tx_st_d = tx_par_en_q ? StParity : StStop;
                        end else begin
                            tx_n_d = tx_n_q + 3'd1;
                        end
                    end else begin
                        tx_s_d = tx_s_q + 5'd1;
                    end
                end
            end
            StParity: begin
                tx_d = tx_par_q;
                if (tick) begin
                    if (tx_s_q == BitEnd) begin
                        tx_st_d = StStop;
                        tx_s_d  = '0;
                    end else begin
                        tx_s_d = tx_s_q + 5'd1;
                    end
                end
            end
            StStop: if (tick) begin
                if (tx_s_q == tx_stop_end) begin
                    tx_pop  = 1'b1;
                    tx_st_d = StIdle;
                end else begin
                    tx_s_d = tx_s_q + 5'd1;
                end
            end
            default: tx_st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_st_q      <= StIdle;
            rx_s_q       <= '0;
            rx_n_q       <= '0;
            rx_b_q       <= '0;
            rx_perr_q    <= 1'b0;
            rx_dbits_q   <= Dbits8;
            rx_par_en_q  <= 1'b0;
            rx_par_odd_q <= 1'b0;
            overrun_q    <= 1'b0;
            tx_st_q      <= StIdle;
            tx_s_q       <= '0;
            tx_n_q       <= '0;
            tx_b_q       <= '0;
            tx_par_q     <= 1'b0;
            tx_dbits_q   <= Dbits8;
            tx_par_en_q  <= 1'b0;
            tx_stop2_q   <= 1'b0;
            tx_q         <= 1'b1;
        end else begin
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            rx_st_q      <= rx_st_d;
            rx_s_q       <= rx_s_d;
            rx_n_q       <= rx_n_d;
            rx_b_q       <= rx_b_d;
            rx_perr_q    <= rx_perr_d;
            rx_dbits_q   <= rx_dbits_d;
            rx_par_en_q  <= rx_par_en_d;
            rx_par_odd_q <= rx_par_odd_d;
            overrun_q    <= overrun_d;
            tx_st_q      <= tx_st_d;
            tx_s_q       <= tx_s_d;
            tx_n_q       <= tx_n_d;
            tx_b_q       <= tx_b_d;
            tx_par_q     <= tx_par_d;
            tx_dbits_q   <= tx_dbits_d;
            tx_par_en_q  <= tx_par_en_d;
            tx_stop2_q   <= tx_stop2_d;
            tx_q         <= tx_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = (tx_st_q != StIdle) | ~tx_empty;
    assign r_data  = rx_head[7:0];
    assign r_perr  = rx_head[8];
    assign r_ferr  = rx_head[9];
    assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_cfg.sv
// Randomized self-checking bench for uart_cfg: serial frames are predicted from
// the framing rules (bit lists, ones-count parity) and compared with tx and the RX FIFO.
module tb_uart_cfg;

    localparam int unsigned FIFO_W   = 2;
    localparam int unsigned DVSR_BIT = 16;
    localparam int          BIT_CLK  = 64;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [DVSR_BIT-1:0] dvsr = 16'd4;
    logic [1:0]          cfg_dbits = 2'b11;
    logic                cfg_par_en = 1'b0, cfg_par_odd = 1'b0, cfg_stop2 = 1'b0;
    logic                rd_uart = 1'b0, wr_uart = 1'b0, err_clr = 1'b0;
    logic [7:0]          w_data = 8'h00;
    logic                loop = 1'b1, drv_rx = 1'b1;
    logic                rx, tx, tx_full, tx_busy, rx_empty, r_perr, r_ferr, overrun;
    logic [7:0]          r_data;

    int n_vec = 0;
    int n_err = 0;

    assign rx = loop ? tx : drv_rx;

    always #5 clk = ~clk;

    uart_cfg #(.FIFO_W(FIFO_W), .DVSR_BIT(DVSR_BIT)) dut (
        .clk         (clk),
        .reset       (reset),
        .dvsr        (dvsr),
        .cfg_dbits   (cfg_dbits),
        .cfg_par_en  (cfg_par_en),
        .cfg_par_odd (cfg_par_odd),
        .cfg_stop2   (cfg_stop2),
        .rd_uart     (rd_uart),
        .wr_uart     (wr_uart),
        .w_data      (w_data),
        .err_clr     (err_clr),
        .rx          (rx),
        .tx          (tx),
        .tx_full     (tx_full),
        .tx_busy     (tx_busy),
        .rx_empty    (rx_empty),
        .r_data      (r_data),
        .r_perr      (r_perr),
        .r_ferr      (r_ferr),
        .overrun     (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference frame: start, data LSB first, optional parity, stop bit(s).
    function automatic void build_frame(input logic [7:0] d, input int nbits, input bit pe,
                                        input bit po, input bit s2,
                                        output logic [11:0] bits, output int len);
        int ones;
        ones = 0;
        bits = '0;
        len  = 1;
        for (int i = 0; i < nbits; i++) begin
            bits[len] = d[i];
            ones += int'(d[i]);
            len++;
        end
        if (pe) begin
            bits[len] = po ? (ones % 2 == 0) : (ones % 2 == 1);
            len++;
        end
        bits[len] = 1'b1;
        len++;
        if (s2) begin
            bits[len] = 1'b1;
            len++;
        end
    endfunction

    task automatic set_cfg(input logic [1:0] db, input bit pe, input bit po, input bit s2);
        @(negedge clk);
        cfg_dbits = db; cfg_par_en = pe; cfg_par_odd = po; cfg_stop2 = s2;
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        w_data = d; wr_uart = 1'b1;
        @(negedge clk);
        wr_uart = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        rd_uart = 1'b1;
        @(negedge clk);
        rd_uart = 1'b0;
    endtask

    task automatic wait_rx(input int budget);
        int w;
        w = 0;
        while (rx_empty && w < budget) begin
            @(negedge clk);
            w++;
        end
    endtask

    // Loopback frame: check tx bit centres, frame length and the received word.
    task automatic tx_and_check(input string tag, input logic [7:0] d, input logic [1:0] db,
                                input bit pe, input bit po, input bit s2);
        logic [11:0] bits;
        int          len, lat, dur, nbits;
        nbits = int'(db) + 5;
        build_frame(d, nbits, pe, po, s2, bits, len);
        loop = 1'b1;
        set_cfg(db, pe, po, s2);
        push(d);
        lat = 1;
        while (tx !== 1'b0 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("%s start_lat(%0d)", tag, lat), 32'(lat <= 8), 32'd1);
        repeat (BIT_CLK / 2) @(negedge clk);
        check($sformatf("%s busy", tag), 32'(tx_busy), 32'd1);
        for (int i = 0; i < len; i++) begin
            check($sformatf("%s bit%0d", tag, i), 32'(tx), 32'(bits[i]));
            if (i < len - 1) repeat (BIT_CLK) @(negedge clk);
        end
        dur = BIT_CLK / 2 + BIT_CLK * (len - 1);
        while (tx_busy && dur < BIT_CLK * len + 64) begin
            @(negedge clk);
            dur++;
        end
        check($sformatf("%s frame_len(%0d)", tag, dur),
              32'(dur >= BIT_CLK * len - 8 && dur <= BIT_CLK * len + 8), 32'd1);
        wait_rx(200);
        check($sformatf("%s rx_empty", tag), 32'(rx_empty), 32'd0);
        check($sformatf("%s r_data", tag), 32'(r_data), 32'(d % (1 << nbits)));
        check($sformatf("%s r_perr", tag), 32'(r_perr), 32'd0);
        check($sformatf("%s r_ferr", tag), 32'(r_ferr), 32'd0);
        pop();
    endtask

    // Bench-driven RX frame, optionally with a wrong parity bit or a low stop bit.
    task automatic rx_drive_check(input string tag, input logic [7:0] d, input logic [1:0] db,
                                  input bit pe, input bit po, input bit flip,
                                  input bit stop_low);
        logic [11:0] bits;
        int          len, nbits, hold;
        nbits = int'(db) + 5;
        build_frame(d, nbits, pe, po, 1'b0, bits, len);
        if (pe && flip) bits[len-2] = ~bits[len-2];
        loop = 1'b0;
        drv_rx = 1'b1;
        set_cfg(db, pe, po, 1'b0);
        repeat (20) @(negedge clk);
        for (int i = 0; i < len; i++) begin
            drv_rx = (i == len - 1 && stop_low) ? 1'b0 : bits[i];
            hold = (i == len - 1 && stop_low) ? 44 : BIT_CLK;
            repeat (hold) @(negedge clk);
        end
        drv_rx = 1'b1;
        wait_rx(300);
        check($sformatf("%s rx_empty", tag), 32'(rx_empty), 32'd0);
        check($sformatf("%s r_data", tag), 32'(r_data), 32'(d % (1 << nbits)));
        check($sformatf("%s r_perr", tag), 32'(r_perr), 32'(pe && flip));
        check($sformatf("%s r_ferr", tag), 32'(r_ferr), 32'(stop_low));
        pop();
        repeat (100) @(negedge clk);
        check($sformatf("%s drained", tag), 32'(rx_empty), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] d;
        int         w;

        repeat (5) @(negedge clk);
        check("rst tx", 32'(tx), 32'd1);
        check("rst tx_busy", 32'(tx_busy), 32'd0);
        check("rst tx_full", 32'(tx_full), 32'd0);
        check("rst rx_empty", 32'(rx_empty), 32'd1);
        check("rst overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        tx_and_check("8N1_A5", 8'hA5, 2'b11, 1'b0, 1'b0, 1'b0);
        tx_and_check("7E2_C1", 8'hC1, 2'b10, 1'b1, 1'b0, 1'b1);
        check("7E2 tx_busy idle", 32'(tx_busy), 32'd0);

        for (int k = 0; k < 6; k++) begin
            tx_and_check($sformatf("rnd_tx%0d", k), 8'($urandom), 2'($urandom_range(0, 3)),
                         1'($urandom), 1'($urandom), 1'($urandom));
        end

        rx_drive_check("8O1_perr", 8'h03, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        rx_drive_check("8N1_ferr", 8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            rx_drive_check($sformatf("rnd_rx%0d", k), 8'($urandom), 2'($urandom_range(0, 3)),
                           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        // Five frames into a four-word RX FIFO with no reads.
        loop = 1'b1;
        set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            d = 8'($urandom);
            q.push_back(d);
            w = 0;
            while (tx_full && w < 2000) begin
                @(negedge clk);
                w++;
            end
            push(d);
        end
        w = 0;
        while (tx_busy && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check("ovr tx drained", 32'(tx_busy), 32'd0);
        repeat (100) @(negedge clk);
        check("ovr set", 32'(overrun), 32'd1);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("ovr cleared", 32'(overrun), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ovr word%0d present", k), 32'(rx_empty), 32'd0);
            check($sformatf("ovr word%0d data", k), 32'(r_data), 32'(q[k]));
            pop();
        end
        check("ovr 5th absent", 32'(rx_empty), 32'd1);

        // Short low glitch must be rejected as a false start.
        loop = 1'b0;
        @(negedge clk);
        drv_rx = 1'b0;
        repeat (12) @(negedge clk);
        drv_rx = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch rx_empty", 32'(rx_empty), 32'd1);
        check("glitch overrun", 32'(overrun), 32'd0);

        // Reset in the middle of an all-zero frame.
        loop = 1'b1;
        push(8'h00);
        repeat (200) @(negedge clk);
        check("mid pre tx", 32'(tx), 32'd0);
        reset = 1'b0;
        #1;
        check("mid rst tx", 32'(tx), 32'd1);
        check("mid rst tx_busy", 32'(tx_busy), 32'd0);
        check("mid rst rx_empty", 32'(rx_empty), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (200) @(negedge clk);
        check("post rst tx", 32'(tx), 32'd1);
        check("post rst rx_empty", 32'(rx_empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
